mouse_cursor: RTL
=================

Name: mouse_cursor

Overview:
- Downstream consumer of the PS/2 mouse packet receiver.
- Takes the receiver's decoded packet (dav, buttons, sign, overflow, parity, X/Y magnitude bytes), checks X/Y byte parity, and accumulates signed deltas into a clamped screen cursor position.
- Presents position and button state to the display/overlay logic, which runs on the CLK domain.
- dav is produced on the PS/2 clock domain, so it is synchronised here.

Parameters:
- XMAX, 639: largest legal cursor X.
- YMAX, 479: largest legal cursor Y.
- XINIT, 320: cursor X after reset.
- YINIT, 240: cursor Y after reset.
- SHIFT, 0: sensitivity; each delta is arithmetically right-shifted by SHIFT (0..3).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- dav  input  1  packet-valid level from receiver (PS/2 clock domain); rises when a packet completes.
- button  input  2  [1]=left, [0]=right.
- sign  input  2  [1]=X sign, [0]=Y sign.
- ovf  input  2  [1]=X overflow, [0]=Y overflow.
- parity  input  3  [1]=X byte parity, [2]=Y byte parity, [0] unused.
- mousexdata  input  8  X delta low byte.
- mouseydata  input  8  Y delta low byte.
- cursorx  output  10  cursor X, 0..XMAX.
- cursory  output  10  cursor Y, 0..YMAX (0 = top).
- lbtn  output  1  left button state.
- rbtn  output  1  right button state.
- upd  output  1  one-CLK pulse when a packet has been applied.
- perr  output  1  one-CLK pulse when a packet is rejected for parity.
- pktcnt  output  8  accepted packets, wraps 255->0.
- errcnt  output  8  rejected packets, saturates at 255.

Behaviour:

Clock and reset:
- Single clock CLK; reset is asynchronous and active-high.
- Reset values: cursorx=XINIT, cursory=YINIT, lbtn=rbtn=0, upd=perr=0, pktcnt=errcnt=0, FSM=IDLE, pending=0.
- The three dav synchroniser flops (s1, s2, s3) reset to 1. A dav already high at reset release is therefore not an event.
- Reset asserted mid-packet aborts processing immediately; no partial update is visible.

Synchronisation and event detection:
- dav passes through s1, then s2; s3 holds the previous s2.
- Event = s2 & ~s3.
- Input buses are sampled only at the cycle the event is seen; they are stable then because the receiver keeps them static while dav is high.

FSM states: IDLE, CHECK, UPDX, UPDY, DONE.
- IDLE: on event (or pending=1), capture all input buses into internal registers, clear pending, go to CHECK.
- CHECK: X parity ok = ^{mousexdata,parity[1]}==1; Y parity ok = ^{mouseydata,parity[2]}==1 (odd parity).
  - Both ok: go to UPDX.
  - Either fails: perr=1 for one cycle, errcnt+1 (saturating), go to IDLE. Cursor and buttons are unchanged.
- UPDX:
  - dx = 9-bit two's complement {sign[1],mousexdata}, then arithmetic >>> SHIFT.
  - If ovf[1]=1, dx=0.
  - sum = 11-bit signed cursorx + dx.
  - sum<0 -> 0; sum>XMAX -> XMAX; else sum.
  - Go to UPDY.
- UPDY:
  - dy formed the same way from {sign[0],mouseydata}, zeroed when ovf[0]=1.
  - Mouse +Y is up, so sum = cursory − dy.
  - Clamp to 0..YMAX.
  - Go to DONE.
- DONE:
  - lbtn=button[1], rbtn=button[0].
  - upd=1 for one cycle; pktcnt+1 (wrapping).
  - cursorx, cursory, lbtn and rbtn all become visible in the same cycle as upd.
  - Go to IDLE.

Latency and overlapping events:
- Counting the CLK edge that first samples dav=1 as edge 1, upd is high after edge 6 for exactly one cycle.
- An event arriving while the FSM is not in IDLE sets pending (one-deep).
- Further events while pending=1 are dropped.
- Arithmetic shift rounds toward −inf, e.g. −1>>>1 = −1.

Test Plan:
- Reset, no dav -> cursorx=320, cursory=240, lbtn=rbtn=0, pktcnt=errcnt=0, upd never pulses.
- dav rise with mousexdata=0x0A, sign=00, mouseydata=0x05, parity bits odd-correct, button=2'b10 -> upd pulse after edge 6; cursorx=330, cursory=235, lbtn=1, rbtn=0, pktcnt=1.
- From (330,235): X delta sign=1, data=0x00 (−256) -> cursorx=74. Repeat -> cursorx clamps to 0. Y delta −256 three times -> cursory clamps to 479.
- Valid X delta +100 with ovf[1]=1 -> cursorx unchanged, Y still applied, upd pulses.
- Wrong parity[1] with mousexdata=0x01 -> perr pulse, errcnt=1, cursor and buttons unchanged, no upd.
- Reset asserted while FSM is in UPDX -> outputs return to reset values. dav held high through reset release -> no event; next low-to-high dav is processed normally.

Source files
------------

// File: rtl/mouse_cursor.sv
// PS/2 mouse packet consumer: synchronises dav, checks X/Y byte parity and
// accumulates signed, optionally scaled deltas into a clamped cursor position.
module mouse_cursor #(
    parameter int XMAX  = 639,
    parameter int YMAX  = 479,
    parameter int XINIT = 320,
    parameter int YINIT = 240,
    parameter int SHIFT = 0
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       dav,
    input  logic [1:0] button,
    input  logic [1:0] sign,
    input  logic [1:0] ovf,
    input  logic [2:0] parity,
    input  logic [7:0] mousexdata,
    input  logic [7:0] mouseydata,
    output logic [9:0] cursorx,
    output logic [9:0] cursory,
    output logic       lbtn,
    output logic       rbtn,
    output logic       upd,
    output logic       perr,
    output logic [7:0] pktcnt,
    output logic [7:0] errcnt
);

    typedef enum logic [2:0] {IDLE, CHECK, UPDX, UPDY, DONE} state_t;

    state_t      state, nstate;
    logic        s1, s2, s3, ev, pending;
    logic [1:0]  btn_q, sgn_q, ovf_q, par_q;
    logic [7:0]  xd_q, yd_q;
    logic [9:0]  nx;
    logic        xok, yok;
    logic signed [8:0] dx_raw, dy_raw, dx, dy;
    logic [10:0] sumx, sumy;
    logic [9:0]  clampx, clampy;
    logic        unused_par;

    assign unused_par = parity[0];
    assign ev = s2 & ~s3;

    assign xok = ^{xd_q, par_q[0]};
    assign yok = ^{yd_q, par_q[1]};

    assign dx_raw = {sgn_q[1], xd_q};
    assign dy_raw = {sgn_q[0], yd_q};
    assign dx     = ovf_q[1] ? 9'sd0 : (dx_raw >>> SHIFT);
    assign dy     = ovf_q[0] ? 9'sd0 : (dy_raw >>> SHIFT);

    // Mouse +Y points up while screen Y grows downward, hence the subtraction.
    assign sumx = {1'b0, cursorx} + {{2{dx[8]}}, dx};
    assign sumy = {1'b0, cursory} - {{2{dy[8]}}, dy};

    always_comb begin
        clampx = sumx[9:0];
        if (sumx[10])              clampx = 10'd0;
        else if (sumx > 11'(XMAX)) clampx = 10'(XMAX);
        clampy = sumy[9:0];
        if (sumy[10])              clampy = 10'd0;
        else if (sumy > 11'(YMAX)) clampy = 10'(YMAX);
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (ev || pending) nstate = CHECK;
            CHECK:   nstate = (xok && yok) ? UPDX : IDLE;
            UPDX:    nstate = UPDY;
            UPDY:    nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            // Synchroniser resets high so a dav already asserted is not an edge.
            s1      <= 1'b1;
            s2      <= 1'b1;
            s3      <= 1'b1;
            pending <= 1'b0;
            btn_q   <= '0;
            sgn_q   <= '0;
            ovf_q   <= '0;
            par_q   <= '0;
            xd_q    <= '0;
            yd_q    <= '0;
            nx      <= 10'(XINIT);
            cursorx <= 10'(XINIT);
            cursory <= 10'(YINIT);
            lbtn    <= 1'b0;
            rbtn    <= 1'b0;
            upd     <= 1'b0;
            perr    <= 1'b0;
            pktcnt  <= '0;
            errcnt  <= '0;
        end else begin
            state <= nstate;
            s1    <= dav;
            s2    <= s1;
            s3    <= s2;
            upd   <= 1'b0;
            perr  <= 1'b0;

            if (state == IDLE) begin
                if (ev || pending) begin
                    btn_q   <= button;
                    sgn_q   <= sign;
                    ovf_q   <= ovf;
                    par_q   <= parity[2:1];
                    xd_q    <= mousexdata;
                    yd_q    <= mouseydata;
                    pending <= 1'b0;
                end
            end else if (ev) begin
                pending <= 1'b1;
            end

            if (state == CHECK && !(xok && yok)) begin
                perr <= 1'b1;
                if (errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
            end

            if (state == UPDX) nx <= clampx;

            // Commit everything together so it appears alongside the upd pulse.
            if (state == UPDY) begin
                cursorx <= nx;
                cursory <= clampy;
                lbtn    <= btn_q[1];
                rbtn    <= btn_q[0];
                upd     <= 1'b1;
                pktcnt  <= pktcnt + 8'd1;
            end
        end
    end

endmodule
